// File: rtl/ram_row_streamer.sv
// Strided RAM row reader streaming each returned word over valid/ready.
// Latency: first address 1 cycle after start, first beat 3 cycles after start.
// Backpressure: credit issue bounds FIFO entries plus in-flight reads to 2.

module sync_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_vld,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop_vld,
    output logic [W-1:0]                 head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop_vld)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push_vld, pop_vld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module ram_row_streamer #(
    parameter int AW = 11,
    parameter int MW = 8,
    parameter int DW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic [AW-1:0]      stride,
    input  logic [AW:0]        num_rows,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      ram_addr,
    output logic [MW-1:0]      ram_we,
    output logic [MW*DW-1:0]   ram_d,
    input  logic [MW*DW-1:0]   ram_q,
    output logic [MW*DW-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state, state_nxt;
    logic          done_nxt;
    logic [AW:0]   rows_left;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] stride_q;
    logic [AW-1:0] last_addr;
    logic          inflight;
    logic [1:0]    fifo_count;
    logic [2:0]    credit;
    logic          pop;
    logic          issue;

    assign ram_we    = '0;
    assign ram_d     = '0;
    assign busy      = (state != IDLE);
    assign out_valid = (fifo_count != 2'd0);
    assign pop       = out_valid & out_ready;

    // A same-cycle pop frees a slot, so it counts toward the issue credit.
    assign credit = {1'b0, fifo_count} + {2'b00, inflight};
    assign issue  = (state == RUN) && (rows_left != '0) &&
                    (credit < (3'd2 + {2'b00, pop}));

    assign ram_addr = issue ? next_addr : last_addr;

    sync_fifo #(.W(MW*DW), .DEPTH(2)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (inflight),
        .push_dat (ram_q),
        .pop_vld  (pop),
        .head_dat (out_data),
        .count    (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_rows == '0) done_nxt  = 1'b1;
                    else                state_nxt = RUN;
                end
            end
            RUN: begin
                if (issue && rows_left == (AW+1)'(1)) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!inflight && fifo_count == 2'd1 && pop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            done      <= 1'b0;
            rows_left <= '0;
            next_addr <= '0;
            stride_q  <= '0;
            last_addr <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= done_nxt;
            inflight <= issue;
            if (state == IDLE && start && num_rows != '0) begin
                rows_left <= num_rows;
                next_addr <= base_addr;
                stride_q  <= stride;
            end else if (issue) begin
                rows_left <= rows_left - (AW+1)'(1);
                next_addr <= next_addr + stride_q;
                last_addr <= next_addr;
            end
        end
    end
endmodule

// File: tb/tb_ram_row_streamer.sv
// Bench for ram_row_streamer: RAM model, expected-beat queue built from base/stride arithmetic.
module tb_ram_row_streamer;
    localparam int AW = 11, MW = 8, DW = 8, W = MW * DW, DEPTH = 1 << AW;

    logic            clk = 1'b0;
    logic            reset, start, busy, done, out_valid, out_ready;
    logic [AW-1:0]   base_addr, stride, ram_addr;
    logic [AW:0]     num_rows;
    logic [MW-1:0]   ram_we;
    logic [W-1:0]    ram_d, ram_q, out_data;
    logic [W-1:0]    mem [DEPTH];
    logic [W-1:0]    exp_q [$];
    int              checks = 0, errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) ram_q <= mem[ram_addr];

    ram_row_streamer #(.AW(AW), .MW(MW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
        .num_rows(num_rows), .busy(busy), .done(done), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_d(ram_d), .ram_q(ram_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    endtask

    // Builds the expected beat list, then pulses start for one cycle; returns at negedge of T+1.
    task automatic start_xfer(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [AW:0] n);
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) exp_q.push_back(mem[(int'(b) + i * int'(s)) % DEPTH]);
        @(negedge clk);
        start = 1'b1; base_addr = b; stride = s; num_rows = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; stride = '0; num_rows = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy, done, out_valid} !== 3'b000)
            begin errors++; $display("FAIL reset_flags busy/done/valid got %b want 000", {busy, done, out_valid}); end
        checks++;
        if (ram_addr !== '0 || ram_we !== '0 || ram_d !== '0 || out_data !== '0)
            begin errors++; $display("FAIL reset_buses addr=%0h we=%0h d=%0h data=%0h want all 0", ram_addr, ram_we, ram_d, out_data); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_v;
        for (int k = 0; k < DEPTH; k++) mem[k] = 64'(k) * 64'h0101010101010101;
        out_ready = 1'b1;
        start_xfer(11'd4, 11'd1, 12'd5);
        for (int k = 1; k <= 10; k++) begin
            #1;
            checks++;
            if (ram_we !== '0 || ram_d !== '0) begin errors++; $display("FAIL basic_we k=%0d we=%0h d=%0h want 0", k, ram_we, ram_d); end
            if (k <= 5) begin
                checks++;
                if (ram_addr !== AW'(3 + k)) begin errors++; $display("FAIL basic_addr k=%0d got %0d want %0d", k, ram_addr, 3 + k); end
            end
            exp_v = (k >= 3 && k <= 7);
            checks++;
            if (out_valid !== exp_v) begin errors++; $display("FAIL basic_valid k=%0d got %b want %b", k, out_valid, exp_v); end
            if (exp_v && exp_q.size() > 0) begin
                checks++;
                if (out_data !== exp_q[0]) begin errors++; $display("FAIL basic_data k=%0d got %h want %h", k, out_data, exp_q[0]); end
                void'(exp_q.pop_front());
            end
            checks++;
            if (done !== (k == 8)) begin errors++; $display("FAIL basic_done k=%0d got %b want %b", k, done, k == 8); end
            checks++;
            if (busy !== (k <= 7)) begin errors++; $display("FAIL basic_busy k=%0d got %b want %b", k, busy, k <= 7); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int beats = 0, issued = 0, dones = 0;
        logic stalled = 1'b0;
        logic [W-1:0] held = '0;
        logic [AW-1:0] prev_addr = ram_addr;
        out_ready = 1'b1;
        start_xfer(11'd4, 11'd1, 12'd5);
        for (int k = 1; k <= 60 && dones == 0; k++) begin
            out_ready = (k % 4 == 1) || (k % 4 == 0);
            #1;
            if (ram_addr !== prev_addr) begin issued++; prev_addr = ram_addr; end
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held)
                    begin errors++; $display("FAIL bp_hold k=%0d valid=%b data=%h want 1 %h", k, out_valid, out_data, held); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0])
                    begin errors++; $display("FAIL bp_data k=%0d got %h left=%0d", k, out_data, exp_q.size()); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                beats++;
            end
            checks++;
            if (issued - beats > 2) begin errors++; $display("FAIL bp_occupancy k=%0d got %0d want <=2", k, issued - beats); end
            stalled = out_valid && !out_ready;
            held = out_data;
            if (done) begin
                dones++;
                checks++;
                if (beats != 5 || busy !== 1'b0) begin errors++; $display("FAIL bp_done beats=%0d busy=%b want 5 0", beats, busy); end
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1 || issued != 5) begin errors++; $display("FAIL bp_total dones=%0d issued=%0d want 1 5", dones, issued); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] addrs [4] = '{11'd2046, 11'd1, 11'd4, 11'd7};
        fill_random();
        out_ready = 1'b1;
        start_xfer(11'd2046, 11'd3, 12'd4);
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (k <= 4) begin
                checks++;
                if (ram_addr !== addrs[k-1]) begin errors++; $display("FAIL wrap_addr k=%0d got %0d want %0d", k, ram_addr, addrs[k-1]); end
            end
            if (k >= 3 && k <= 6) begin
                checks++;
                if (out_valid !== 1'b1 || exp_q.size() == 0 || out_data !== exp_q[0])
                    begin errors++; $display("FAIL wrap_data k=%0d valid=%b got %h", k, out_valid, out_data); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            checks++;
            if (done !== (k == 7)) begin errors++; $display("FAIL wrap_done k=%0d got %b want %b", k, done, k == 7); end
            @(negedge clk);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        start_xfer(11'd5, 11'd1, 12'd0);
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== (k == 1))
                begin errors++; $display("FAIL zero k=%0d valid=%b busy=%b done=%b want 0 0 %b", k, out_valid, busy, done, k == 1); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            int beats = 0, dones = 0;
            logic [AW:0] n = (AW+1)'($urandom_range(1, 24));
            fill_random();
            start_xfer(AW'($urandom), AW'($urandom), n);
            for (int k = 1; k <= 400 && dones == 0; k++) begin
                out_ready = ($urandom_range(0, 2) != 0);
                #1;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0 || out_data !== exp_q[0])
                        begin errors++; $display("FAIL rand_data t=%0d k=%0d got %h left=%0d", t, k, out_data, exp_q.size()); end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    beats++;
                end
                if (done) dones++;
                @(negedge clk);
            end
            checks++;
            if (dones != 1 || beats != int'(n)) begin errors++; $display("FAIL rand_count t=%0d beats=%0d dones=%0d want %0d 1", t, beats, dones, n); end
        end
    endtask

    task automatic test_full_length();
        int beats = 0, dones = 0, tail = -1, k = 0;
        fill_random();
        out_ready = 1'b1;
        start_xfer(11'd0, 11'd1, 12'd2048);
        while (k < 8000 && tail != 0) begin
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0])
                    begin errors++; $display("FAIL full_data beat=%0d got %h left=%0d", beats, out_data, exp_q.size()); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                beats++;
            end
            if (done) begin dones++; tail = 5; end
            else if (tail > 0) tail--;
            // Spurious start pulses while busy must not restart the transfer.
            start = busy && (k % 101 == 50);
            base_addr = AW'($urandom); num_rows = 12'd5;
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (dones != 1 || beats != 2048) begin errors++; $display("FAIL full_total beats=%0d dones=%0d want 2048 1", beats, dones); end
    endtask

    task automatic test_reset_midrun();
        int beats = 0, k = 0;
        fill_random();
        out_ready = 1'b1;
        start_xfer(11'd100, 11'd7, 12'd10);
        while (beats < 3 && k < 20) begin
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                beats++;
            end
            if (beats < 3) @(negedge clk);
            k++;
        end
        checks++;
        if (beats != 3) begin errors++; $display("FAIL midrun_pre beats=%0d want 3", beats); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({busy, done, out_valid} !== 3'b000 || ram_addr !== '0 || out_data !== '0 || ram_we !== '0 || ram_d !== '0)
            begin errors++; $display("FAIL midrun_reset busy=%b done=%b valid=%b addr=%0h data=%h want all 0", busy, done, out_valid, ram_addr, out_data); end
        reset = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({busy, done, out_valid} !== 3'b000)
                begin errors++; $display("FAIL midrun_quiet j=%0d busy/done/valid got %b want 000", j, {busy, done, out_valid}); end
        end
        start_xfer(11'd0, 11'd1, 12'd2);
        beats = 0;
        for (int m = 1; m <= 7; m++) begin
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0 || out_data !== exp_q[0])
                    begin errors++; $display("FAIL midrun_data m=%0d got %h left=%0d", m, out_data, exp_q.size()); end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                beats++;
            end
            checks++;
            if (done !== (m == 5)) begin errors++; $display("FAIL midrun_done m=%0d got %b want %b", m, done, m == 5); end
            @(negedge clk);
        end
        checks++;
        if (beats != 2) begin errors++; $display("FAIL midrun_beats got %0d want 2", beats); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_random();
        test_full_length();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
